// File: rtl/spk_out_fifo.sv
// -----------------------------------------------------------------------------
// spk_out_fifo
//
// Spike output buffer sitting behind the neuron work controller. Every cycle
// it sees the fire decision for the neuron currently addressed, and queues the
// {z,y,x} identifier of each neuron that fired. Queued identifiers are handed
// to the downstream router over a valid/ready handshake. An early "full" flag
// stalls neuron scanning while FULL_MARGIN entries are still free, so that
// neurons already in flight can still be absorbed.
//
// Optional feature macro: SPK_OUT_DROP_CNT_EN
//   defined   -> spk_drop_cnt counts pushes dropped at cnt == DEPTH
//                (saturating at 16'hFFFF, cleared only by rst)
//   undefined -> spk_drop_cnt tied to 0; drops still happen silently
//
// Ports
//   clk                  clock
//   rst                  synchronous active-high reset
//   soma_fire_vld        fire decision valid this cycle
//   soma_fire            neuron fired (qualified by soma_fire_vld)
//   config_spk_out_neuid identifier aligned with soma_fire_vld
//   flush                discard all queued spikes
//   spk_out_config_full  backpressure to work controller
//   spk_out_vld          head entry valid
//   spk_out_data         head identifier (zero when empty)
//   spk_out_rdy          downstream accepts head
//   spk_drop_cnt         dropped-spike counter
// -----------------------------------------------------------------------------
module spk_out_fifo #(
    parameter int SW          = 24,
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int FULL_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          soma_fire_vld,
    input  logic          soma_fire,
    input  logic [SW-1:0] config_spk_out_neuid,
    input  logic          flush,
    output logic          spk_out_config_full,
    output logic          spk_out_vld,
    output logic [SW-1:0] spk_out_data,
    input  logic          spk_out_rdy,
    output logic [15:0]   spk_drop_cnt
);

    localparam int            FULL_TH  = DEPTH - FULL_MARGIN;
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW:0]   FULL_C   = FULL_TH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [SW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    logic push_req;
    logic at_depth;
    logic push;
    logic pop;
    logic drop;

    // Acceptance is judged on the registered count, so a pop in the same
    // cycle never frees room for a push arriving at cnt == DEPTH.
    assign push_req = soma_fire_vld & soma_fire & ~flush;
    assign at_depth = (cnt == DEPTH_C);
    assign push     = push_req & ~at_depth;
    assign drop     = push_req & at_depth;
    assign pop      = spk_out_vld & spk_out_rdy & ~flush;

    // Outputs depend only on registered state: no input-to-output path.
    assign spk_out_vld         = (cnt != '0);
    assign spk_out_data        = spk_out_vld ? mem[rp] : '0;
    assign spk_out_config_full = (cnt >= FULL_C);

    // Control state: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PTR_ONE;
            if (pop)  rp <= rp + PTR_ONE;
            if (push && !pop)      cnt <= cnt + CNT_ONE;
            else if (pop && !push) cnt <= cnt - CNT_ONE;
        end
    end

    // Storage array is data only and is never reset.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= config_spk_out_neuid;
    end

`ifdef SPK_OUT_DROP_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)       spk_drop_cnt <= '0;
        else if (drop) spk_drop_cnt <= sat_inc(spk_drop_cnt);
    end
`else
    assign spk_drop_cnt = '0;

    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: doc/spk_out_fifo.md
# spk_out_fifo

Spike output buffer on the receiving end of the neuron work controller's spike-out interface. Each cycle it takes the fire decision for the neuron currently addressed by the work controller, together with that neuron's (z,y,x) identifier, and queues fired identifiers in a FIFO. It presents queued identifiers to the downstream router with a valid/ready handshake. It drives the `spk_out_config_full` backpressure flag that stalls neuron scanning.

## Interface
- `SW`, 24, spike identifier width, {z,y,x} with SW/3 bits each
- `DEPTH`, 16, FIFO entries; power of two, ≥ 8
- `AW`, 4, log2(DEPTH)
- `FULL_MARGIN`, 4, free-entry reserve covering neurons already in flight when full is raised; 1 ≤ FULL_MARGIN < DEPTH

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `soma_fire_vld`  in  1  fire decision valid this cycle
- `soma_fire`  in  1  neuron fired (ignored when `soma_fire_vld`=0)
- `config_spk_out_neuid`  in  SW  identifier aligned with `soma_fire_vld`
- `flush`  in  1  discard all queued spikes
- `spk_out_config_full`  out  1  backpressure to work controller
- `spk_out_vld`  out  1  head entry valid
- `spk_out_data`  out  SW  head identifier
- `spk_out_rdy`  in  1  downstream accepts head
- `spk_drop_cnt`  out  16  dropped-spike counter (see Configuration)

## Operation
- Storage: DEPTH×SW register array, write pointer `wp`, read pointer `rp` (AW bits each, wrap modulo DEPTH), occupancy `cnt` (AW+1 bits, 0..DEPTH).
- Push request: `soma_fire_vld && soma_fire && !flush`.
- Push accepted iff `cnt < DEPTH`, evaluated on the registered `cnt` before this cycle's pop. A pop in the same cycle does not make room for a push at `cnt == DEPTH`.
- Push at `cnt == DEPTH` is dropped. The FIFO is not modified, and the drop counter is updated when compiled in.
- Pop: `spk_out_vld && spk_out_rdy`.
- `cnt` update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- `spk_out_vld` = (`cnt != 0`).
- `spk_out_data` = `mem[rp]` when valid, all-zero otherwise.
- While `spk_out_vld`=1 and `spk_out_rdy`=0, `spk_out_data` holds stable.
- `spk_out_config_full` = (`cnt >= DEPTH − FULL_MARGIN`). It is combinational from registered `cnt` only; no input-to-output path.
- `flush`:
  - next cycle `wp`=`rp`=`cnt`=0
  - a push or pop in the flush cycle is ignored
  - `spk_drop_cnt` is not cleared
- Identifiers are stored verbatim; no reordering and no deduplication.

## Timing
- Reset values:
  - `cnt`, `wp`, `rp` = 0
  - `spk_out_vld` = 0
  - `spk_out_data` = 0
  - `spk_out_config_full` = 0
  - `spk_drop_cnt` = 0
- Array contents are not reset.
- Write-to-read latency is 1: a push at edge N makes `spk_out_vld`=1 with that identifier after edge N.
- A pop at edge N presents the next entry (or vld=0) after edge N. Back-to-back pops sustain one spike per cycle.
- Full asserts the cycle after the push that brings `cnt` to DEPTH−FULL_MARGIN, and deasserts the cycle after `cnt` drops below it.
- FULL_MARGIN=4 absorbs the work controller's state-register reaction plus the neuid/soma pipeline. At default sizing, no drop occurs in correct system operation.
- `rst` mid-operation discards all contents on the next edge, identical to power-up.

## Configuration
- Macro: `SPK_OUT_DROP_CNT_EN`.
- Defined:
  - `spk_drop_cnt` increments by 1 on each dropped push
  - saturates at 16'hFFFF
  - cleared only by `rst`
- Undefined:
  - counter logic absent; `spk_drop_cnt` tied to 0
  - drops still occur silently under the same rule

## Test plan
- Reset, then 3 pushes with ids 0x000001, 0x000102, 0x010203 and `spk_out_rdy`=1 → outputs appear in order, each 1 cycle after its push; vld then 0, data 0.
- `spk_out_rdy`=0, 12 consecutive pushes → full rises the cycle after the 12th push (cnt=12); data holds the first id throughout.
- `spk_out_rdy`=0, 18 pushes → cnt stays 16. With `SPK_OUT_DROP_CNT_EN`, drop count = 2; without it, the count is 0. Draining yields exactly the first 16 ids.
- At cnt=16, push and pop in the same cycle → push dropped, cnt=15.
- At cnt=5 with `spk_out_rdy`=1, simultaneous push and pop → cnt stays 5, order preserved.
- Assert `flush` at cnt=9 with a push in the same cycle → next cycle vld=0, full=0, cnt=0. The pushed id never appears; `spk_drop_cnt` is unchanged.
- 40 pushes with `spk_out_rdy`=1 → pointer wrap, ids out in order.
- Reset mid-stream → outputs return to reset values and no stale ids appear.
